// File: rtl/adc_align_pkg.sv
// Shared state type, defaults and counter-width helper for the ADC channel-A frame aligner.
package adc_align_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_VERIFY,
        S_ALIGNED
    } align_state_t;

    localparam logic [7:0] DEF_FRAME_PATTERN = 8'hF0;
    localparam int         DEF_LOCK_CNT      = 64;
    localparam int         DEF_BS_WAIT       = 16;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_MATCH_W = cnt_width(DEF_LOCK_CNT);
    localparam int DEF_WAIT_W  = cnt_width(DEF_BS_WAIT);

endpackage

// File: rtl/adc_frame_align.sv
// Channel-A word-alignment trainer: bitslips the ISERDES until the frame word matches,
// declares alignment after a stable run, and retrains on persistent loss.
module adc_frame_align
    import adc_align_pkg::*;
#(
    parameter int              DW            = 8,
    parameter logic [DW-1:0]   FRAME_PATTERN = DW'(DEF_FRAME_PATTERN),
    parameter int              BS_WAIT       = DEF_BS_WAIT,
    parameter int              LOCK_CNT      = DEF_LOCK_CNT,
    parameter int              MAX_SLIPS     = 8,
    parameter int              ERR_THRESH    = 4
) (
    input  logic          clk_div_a,
    input  logic          sys_rst_n,
    input  logic          gclk_sd_lockeda,
    input  logic [DW-1:0] frame_in,
    input  logic          retrain,
    output logic          bitslip,
    output logic          aligned,
    output logic          train_fail,
    output logic [3:0]    slip_count,
    output logic [15:0]   err_count
);

    localparam int WAIT_W  = cnt_width(BS_WAIT);
    localparam int MATCH_W = cnt_width(LOCK_CNT);
    localparam int MISS_W  = cnt_width(ERR_THRESH);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(BS_WAIT - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(ERR_THRESH - 1);
    localparam logic [3:0]         SLIP_LAST  = 4'(MAX_SLIPS - 1);

    align_state_t         r_state;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [MATCH_W-1:0]   r_match_cnt;
    logic [MISS_W-1:0]    r_miss_cnt;
    logic [3:0]           r_slip_count;
    logic [15:0]          r_err_count;
    logic                 r_train_fail;
    logic                 r_bitslip;
    logic                 r_aligned;

    align_state_t         w_state_nxt;
    logic [WAIT_W-1:0]    w_wait_nxt;
    logic [MATCH_W-1:0]   w_match_nxt;
    logic [MISS_W-1:0]    w_miss_nxt;
    logic [3:0]           w_slip_nxt;
    logic [15:0]          w_err_nxt;
    logic                 w_fail_nxt;
    logic                 w_slip_req;
    logic                 w_hit;

    assign w_hit = (frame_in == FRAME_PATTERN);

    always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_slip_count <= '0;
            r_err_count  <= '0;
            r_train_fail <= 1'b0;
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_match_cnt  <= w_match_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_slip_count <= w_slip_nxt;
            r_err_count  <= w_err_nxt;
            r_train_fail <= w_fail_nxt;
            r_bitslip    <= (w_state_nxt == S_SLIP);
            r_aligned    <= (w_state_nxt == S_ALIGNED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_slip_nxt  = r_slip_count;
        w_err_nxt   = r_err_count;
        w_fail_nxt  = r_train_fail;
        w_slip_req  = 1'b0;

        // retrain outranks lock loss, and both outrank any in-state transition
        if (retrain || !gclk_sd_lockeda) begin
            w_state_nxt = S_IDLE;
            w_wait_nxt  = '0;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
            w_slip_nxt  = '0;
            if (retrain) begin
                w_fail_nxt = 1'b0;
                w_err_nxt  = '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nxt = S_CHECK;
                S_CHECK: begin
                    if (w_hit) begin
                        w_match_nxt = MATCH_W'(1);
                        w_state_nxt = (LOCK_CNT <= 1) ? S_ALIGNED : S_VERIFY;
                    end else begin
                        w_slip_req = 1'b1;
                    end
                end
                S_SLIP: begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) w_state_nxt = S_CHECK;
                    else                          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                end
                S_VERIFY: begin
                    if (w_hit) begin
                        w_match_nxt = r_match_cnt + MATCH_W'(1);
                        if (r_match_cnt == MATCH_LAST) w_state_nxt = S_ALIGNED;
                    end else begin
                        w_slip_req = 1'b1;
                    end
                end
                S_ALIGNED: begin
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        if (r_err_count != '1) w_err_nxt = r_err_count + 16'd1;
                        if (r_miss_cnt == MISS_LAST) begin
                            w_state_nxt = S_CHECK;
                            w_miss_nxt  = '0;
                            w_slip_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // CHECK and VERIFY share one slip path; the wrap marks a full failed search
        if (w_slip_req) begin
            w_state_nxt = S_SLIP;
            w_match_nxt = '0;
            if (r_slip_count == SLIP_LAST) begin
                w_slip_nxt = '0;
                w_fail_nxt = 1'b1;
            end else begin
                w_slip_nxt = r_slip_count + 4'd1;
            end
        end

        if (w_state_nxt == S_ALIGNED && r_state != S_ALIGNED) w_fail_nxt = 1'b0;
    end

    assign bitslip    = r_bitslip;
    assign aligned    = r_aligned;
    assign train_fail = r_train_fail;
    assign slip_count = r_slip_count;
    assign err_count  = r_err_count;

endmodule
